// File: rtl/vme_system_arbiter.sv
// vme_system_arbiter: VME slot-1 system controller. It arbitrates BR3..BR0, drives the BG chain heads and BCLR, and runs the global bus timer.
// Latency: request->grant 3 edges, BBSY->grant release 3 edges, DS strobe->timer BERR BUS_TIMEOUT+3 edges.
// Backpressure: none; a grant is held until BBSY answers it or GRANT_TIMEOUT expires. `enable` low forces IDLE with inactive outputs.
// Optional: define VME_ROUND_ROBIN_EN for round-robin arbitration; in that build BCLR is never driven.
module vme_system_arbiter #(
  parameter int GRANT_TIMEOUT = 64,
  parameter int BUS_TIMEOUT   = 1024,
  parameter int TIMER_WIDTH   = 11
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] vme_bus_request,
  input  logic       vme_bus_busy,
  input  logic       vme_as,
  input  logic [1:0] vme_ds,
  input  logic       vme_dtack,
  input  logic       vme_berr,
  output logic [3:0] vme_bus_grant_out,
  output logic       vme_bus_clear,
  output logic       vme_berr_out,
  output logic [1:0] grant_level,
  output logic       timeout_flag
);

  typedef logic [TIMER_WIDTH-1:0] cnt_t;
  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_BUSY} state_t;

  // The last grant cycle is GRANT_TIMEOUT-1 counts after entry, so the grant is low for exactly GRANT_TIMEOUT edges.
  localparam cnt_t GRANT_LAST = cnt_t'(GRANT_TIMEOUT - 1);
  localparam cnt_t BUS_LIMIT  = cnt_t'(BUS_TIMEOUT);

  // Synchronizer vector: {BR[3:0], BBSY, AS, DS[1:0], DTACK, BERR}. All of these are active-low on the backplane.
  logic [9:0] sync1_d, sync1_q, sync2_d, sync2_q;

  // Internal active-high views of the synchronized backplane signals
  logic [3:0] req_act;
  logic       bbsy_act, as_act, dtack_act, berr_act;
  logic [1:0] ds_act;
  logic       strobe;

  state_t     state_d, state_q;
  cnt_t       gcnt_d, gcnt_q;
  logic [1:0] level_d, level_q;
  logic [3:0] grant_d, grant_q;
  logic       bclr_d, bclr_q;
  cnt_t       tcnt_d, tcnt_q;
  logic       berr_d, berr_q;
  logic       flag_d, flag_q;

`ifdef VME_ROUND_ROBIN_EN
  // Round-robin: search from last-1 downwards and wrap 0->3. The first requester found wins.
  function automatic logic [1:0] pick_level(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] lvl;
    logic [1:0] cand;
    lvl = last;
    for (int i = 4; i >= 1; i--) begin
      cand = last - 2'(i);
      if (req[cand]) lvl = cand;
    end
    return lvl;
  endfunction
`else
  // Fixed priority: BR3 > BR2 > BR1 > BR0
  function automatic logic [1:0] pick_level(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] lvl;
    lvl = last;
    for (int i = 0; i < 4; i++) begin
      if (req[i]) lvl = 2'(i);
    end
    return lvl;
  endfunction
`endif

  assign req_act   = ~sync2_q[9:6];
  assign bbsy_act  = ~sync2_q[5];
  assign as_act    = ~sync2_q[4];
  assign ds_act    = ~sync2_q[3:2];
  assign dtack_act = ~sync2_q[1];
  assign berr_act  = ~sync2_q[0];

  // The data-transfer timer runs only while a strobed cycle waits for an acknowledge.
  assign strobe = as_act & (|ds_act) & ~dtack_act & ~berr_act;

  // Synchronizer next-state values
  always_comb begin
    sync1_d = {vme_bus_request, vme_bus_busy, vme_as, vme_ds, vme_dtack, vme_berr};
    sync2_d = sync1_q;
  end

  // Two-flop synchronizer. It resets to the deasserted (high) backplane level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // Arbitration FSM next state, plus the grant and BCLR values registered alongside the state
  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    level_d = level_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!bbsy_act && (|req_act)) begin
          level_d = pick_level(req_act, level_q);
          gcnt_d  = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A withdrawn request does not end the grant. BBSY wins a tie with the timeout.
        if (bbsy_act) begin
          state_d = ST_BUSY;
        end else if (gcnt_q == GRANT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      ST_BUSY: begin
        if (!bbsy_act) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!enable) begin
      state_d = ST_IDLE;
      gcnt_d  = '0;
      level_d = '0;
    end

    grant_d = 4'hF;
    if (state_d == ST_GRANT) grant_d[level_d] = 1'b0;

    bclr_d = 1'b1;
`ifndef VME_ROUND_ROBIN_EN
    // Ask the owner to release when a strictly higher level is waiting. The request vector shifted down by the level exceeds 1 exactly then.
    if ((state_d == ST_BUSY) && ((req_act >> level_q) > 4'd1)) bclr_d = 1'b0;
`endif
  end

  // Bus timer: saturating count of unacknowledged strobe cycles. BERR is held until both DS return high.
  always_comb begin
    tcnt_d = tcnt_q;
    berr_d = berr_q;
    flag_d = flag_q;
    if (!berr_q) begin
      if (ds_act == 2'b00) begin
        berr_d = 1'b1;
        tcnt_d = '0;
      end else if (!strobe) begin
        tcnt_d = '0;
      end
    end else if (!strobe) begin
      tcnt_d = '0;
    end else if (tcnt_q == BUS_LIMIT) begin
      berr_d = 1'b0;
      flag_d = 1'b1;
    end else begin
      tcnt_d = tcnt_q + 1'b1;
    end
    // The sticky flag survives a disable; only reset clears it.
    if (!enable) begin
      berr_d = 1'b1;
      tcnt_d = '0;
    end
  end

  // State, counters and all registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      gcnt_q  <= '0;
      level_q <= '0;
      grant_q <= 4'hF;
      bclr_q  <= 1'b1;
      tcnt_q  <= '0;
      berr_q  <= 1'b1;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
      level_q <= level_d;
      grant_q <= grant_d;
      bclr_q  <= bclr_d;
      tcnt_q  <= tcnt_d;
      berr_q  <= berr_d;
      flag_q  <= flag_d;
    end
  end

  assign vme_bus_grant_out = grant_q;
  assign vme_bus_clear     = bclr_q;
  assign vme_berr_out      = berr_q;
  assign grant_level       = level_q;
  assign timeout_flag      = flag_q;

endmodule

// File: tb/tb_vme_system_arbiter.sv
// Testbench for vme_system_arbiter: random and directed bus ownership and bus-timer scenarios.
// Stimulus pushes timed expected output transitions; a negedge monitor pops them whenever an output changes.
// Inputs are driven 1 time unit after a rising edge, so "after edge N" equals cyc == N.
module tb_vme_system_arbiter;
  localparam int GT = 64;
  localparam int BT = 16;
  localparam int TW = 11;
`ifdef VME_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] vme_bus_request = 4'hF;
  logic       vme_bus_busy = 1'b1;
  logic       vme_as = 1'b1;
  logic [1:0] vme_ds = 2'b11;
  logic       vme_dtack = 1'b1;
  logic       vme_berr = 1'b1;
  logic [3:0] vme_bus_grant_out;
  logic       vme_bus_clear;
  logic       vme_berr_out;
  logic [1:0] grant_level;
  logic       timeout_flag;

  vme_system_arbiter #(.GRANT_TIMEOUT(GT), .BUS_TIMEOUT(BT), .TIMER_WIDTH(TW)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .vme_bus_request(vme_bus_request), .vme_bus_busy(vme_bus_busy),
    .vme_as(vme_as), .vme_ds(vme_ds), .vme_dtack(vme_dtack), .vme_berr(vme_berr),
    .vme_bus_grant_out(vme_bus_grant_out), .vme_bus_clear(vme_bus_clear),
    .vme_berr_out(vme_berr_out), .grant_level(grant_level), .timeout_flag(timeout_flag)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int cyc; logic [3:0] val; logic [1:0] lvl; } evt_t;
  evt_t q_gnt[$];
  evt_t q_bclr[$];
  evt_t q_berr[$];

  int checks = 0;
  int errors = 0;
  int last_lvl = 0;      // reference model: level of the most recent grant
  bit model_flag = 0;    // reference model: sticky timer flag

  bit mon_en = 0;
  logic [3:0] prev_gnt;
  logic prev_bclr, prev_berr;
  evt_t me;

  // Monitor: every output transition must match the head of its expectation queue, in both cycle and value.
  always @(negedge clock) begin
    if (mon_en) begin
      if (vme_bus_grant_out !== prev_gnt) begin
        checks++;
        if (q_gnt.size() == 0) begin
          errors++;
          $display("FAIL gnt_unexpected cyc=%0d got=%b", cyc, vme_bus_grant_out);
        end else begin
          me = q_gnt.pop_front();
          if (me.cyc != cyc || me.val !== vme_bus_grant_out ||
              (me.val != 4'hF && me.lvl !== grant_level)) begin
            errors++;
            $display("FAIL gnt_event got cyc=%0d bg=%b lvl=%0d exp cyc=%0d bg=%b lvl=%0d",
                     cyc, vme_bus_grant_out, grant_level, me.cyc, me.val, me.lvl);
          end
        end
      end
      if (vme_bus_clear !== prev_bclr) begin
        checks++;
        if (q_bclr.size() == 0) begin
          errors++;
          $display("FAIL bclr_unexpected cyc=%0d got=%b", cyc, vme_bus_clear);
        end else begin
          me = q_bclr.pop_front();
          if (me.cyc != cyc || me.val[0] !== vme_bus_clear) begin
            errors++;
            $display("FAIL bclr_event got cyc=%0d v=%b exp cyc=%0d v=%b", cyc, vme_bus_clear, me.cyc, me.val[0]);
          end
        end
      end
      if (vme_berr_out !== prev_berr) begin
        checks++;
        if (q_berr.size() == 0) begin
          errors++;
          $display("FAIL berr_unexpected cyc=%0d got=%b", cyc, vme_berr_out);
        end else begin
          me = q_berr.pop_front();
          if (me.cyc != cyc || me.val[0] !== vme_berr_out) begin
            errors++;
            $display("FAIL berr_event got cyc=%0d v=%b exp cyc=%0d v=%b", cyc, vme_berr_out, me.cyc, me.val[0]);
          end
        end
      end
    end
    prev_gnt  = vme_bus_grant_out;
    prev_bclr = vme_bus_clear;
    prev_berr = vme_berr_out;
  end

  task automatic push(int which, int c, logic [3:0] v, int l);
    evt_t e;
    e.cyc = c; e.val = v; e.lvl = 2'(l);
    if (which == 0) q_gnt.push_back(e);
    else if (which == 1) q_bclr.push_back(e);
    else q_berr.push_back(e);
  endtask

  function automatic logic [3:0] gmask(int l);
    logic [3:0] m;
    m = 4'hF;
    m[l] = 1'b0;
    return m;
  endfunction

  // Reference arbitration. req is active-high.
  function automatic int model_pick(logic [3:0] req);
    int l;
    if (RR) begin
      for (int i = 1; i <= 4; i++) begin
        l = (last_lvl + 4 - i) % 4;
        if (req[l]) return l;
      end
    end else begin
      for (int j = 3; j >= 0; j--) if (req[j]) return j;
    end
    return 0;
  endfunction

  task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic wait_until(int t);
    while (cyc < t) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q_gnt.size() + q_bclr.size() + q_berr.size()) != 0 && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    repeat (4) begin @(posedge clock); #1; end
    checks++;
    if ((q_gnt.size() + q_bclr.size() + q_berr.size()) != 0) begin
      errors++;
      $display("FAIL drain_missing gnt=%0d bclr=%0d berr=%0d exp 0", q_gnt.size(), q_bclr.size(), q_berr.size());
      q_gnt.delete(); q_bclr.delete(); q_berr.delete();
    end
  endtask

  // One ownership cycle: request, optional grant timeout and re-grant, BBSY answer, optional higher request for BCLR, release.
  task automatic arb_txn(logic [3:0] req, bit to_case, int d, bit clr);
    int c0, w, busy_entry, h, rel;
    @(posedge clock); #1;
    c0 = cyc;
    vme_bus_request = ~req;
    w = model_pick(req);
    last_lvl = w;
    push(0, c0 + 3, gmask(w), w);
    if (to_case) begin
      push(0, c0 + 3 + GT, 4'hF, 0);
      w = model_pick(req);
      last_lvl = w;
      push(0, c0 + 4 + GT, gmask(w), w);
      wait_until(c0 + 4 + GT);
      busy_entry = c0 + 7 + GT;
    end else begin
      wait_until(c0 + 3 + d);
      busy_entry = c0 + 6 + d;
    end
    vme_bus_busy = 1'b0;
    vme_bus_request = 4'hF;
    push(0, busy_entry, 4'hF, 0);
    wait_until(busy_entry + 1);
    h = -1;
    if (clr && last_lvl < 3) begin
      h = $urandom_range(last_lvl + 1, 3);
      vme_bus_request[h] = 1'b0;
      if (!RR) push(1, busy_entry + 4, 4'h0, 0);
    end
    rel = busy_entry + 1 + $urandom_range(4, 10);
    wait_until(rel);
    vme_bus_busy = 1'b1;
    vme_bus_request = 4'hF;
    if (h >= 0 && !RR) push(1, rel + 3, 4'h1, 0);
    wait_drain();
  endtask

  task automatic arb_random();
    int d;
    d = ($urandom_range(0, 3) == 0) ? GT - 3 : $urandom_range(0, GT - 3);
    arb_txn(4'($urandom_range(1, 15)), ($urandom_range(0, 3) == 0), d, $urandom_range(0, 1) == 1);
  endtask

  // Strobe a transfer. DTACK arrives k cycles after DS (k < 0 means never); the timer fires iff the ack is later than BUS_TIMEOUT.
  task automatic timer_txn(logic [1:0] ds, int k);
    int c0, r, rel;
    bit fire;
    @(posedge clock); #1;
    c0 = cyc;
    vme_as = 1'b0;
    vme_ds = ~ds;
    fire = (k < 0) || (k > BT);
    if (fire) begin
      push(2, c0 + BT + 3, 4'h0, 0);
      model_flag = 1'b1;
    end
    r = $urandom_range(1, 4);
    if (k >= 0) begin
      wait_until(c0 + k);
      vme_dtack = 1'b0;
      rel = c0 + k + r;
    end else begin
      rel = c0 + BT + 3 + r;
    end
    wait_until(rel);
    vme_as = 1'b1;
    vme_ds = 2'b11;
    vme_dtack = 1'b1;
    if (fire) push(2, rel + 3, 4'h1, 0);
    wait_drain();
    chk("timeout_flag", 8'(timeout_flag), 8'(model_flag));
  endtask

  initial begin
    int c0, w, rc, rr, e;
    logic [3:0] req;

    repeat (3) begin @(posedge clock); #1; end
    chk("rst_grant", 8'(vme_bus_grant_out), 8'hF);
    chk("rst_bclr", 8'(vme_bus_clear), 8'h1);
    chk("rst_berr", 8'(vme_berr_out), 8'h1);
    chk("rst_level", 8'(grant_level), 8'h0);
    chk("rst_flag", 8'(timeout_flag), 8'h0);
    reset = 1'b1;
    mon_en = 1'b1;
    repeat (3) begin @(posedge clock); #1; end

    // Directed: BR1 answered 2 cycles after the grant, priority pair, grant timeout, BCLR from level 0
    arb_txn(4'b0010, 1'b0, 2, 1'b0);
    arb_txn(4'b0101, 1'b0, 3, 1'b0);
    arb_txn(4'b1000, 1'b1, 0, 1'b0);
    arb_txn(4'b0001, 1'b0, 1, 1'b1);
    arb_txn(4'b1111, 1'b0, GT - 3, 1'b0);
    for (int i = 0; i < 25; i++) arb_random();

    // Bus timer: never acknowledged, then acknowledges around the boundary
    timer_txn(2'b01, -1);
    timer_txn(2'b01, BT);
    timer_txn(2'b10, BT + 1);
    for (int i = 0; i < 6; i++) timer_txn(2'($urandom_range(1, 3)), $urandom_range(BT - 3, BT + 4));

    // Asynchronous reset during GRANT, then re-arbitration from IDLE
    req = 4'($urandom_range(1, 15));
    @(posedge clock); #1;
    c0 = cyc;
    vme_bus_request = ~req;
    w = model_pick(req);
    push(0, c0 + 3, gmask(w), w);
    rc = c0 + 3 + $urandom_range(1, 5);
    wait_until(rc);
    reset = 1'b0;
    push(0, rc, 4'hF, 0);
    #1;
    chk("arst_grant", 8'(vme_bus_grant_out), 8'hF);
    chk("arst_flag", 8'(timeout_flag), 8'h0);
    model_flag = 1'b0;
    last_lvl = 0;
    @(posedge clock); #1;
    rr = cyc;
    reset = 1'b1;
    w = model_pick(req);
    last_lvl = w;
    push(0, rr + 3, gmask(w), w);
    wait_until(rr + 3);
    vme_bus_busy = 1'b0;
    vme_bus_request = 4'hF;
    push(0, rr + 6, 4'hF, 0);
    wait_until(rr + 8);
    vme_bus_busy = 1'b1;
    wait_drain();
    chk("post_rst_flag", 8'(timeout_flag), 8'(model_flag));

    // Enable dropped during GRANT: outputs inactive next edge, no grant while disabled
    req = 4'($urandom_range(1, 15));
    @(posedge clock); #1;
    c0 = cyc;
    vme_bus_request = ~req;
    w = model_pick(req);
    push(0, c0 + 3, gmask(w), w);
    e = c0 + 3 + $urandom_range(1, 5);
    wait_until(e);
    enable = 1'b0;
    push(0, e + 1, 4'hF, 0);
    last_lvl = 0;
    wait_until(e + 1);
    chk("dis_level", 8'(grant_level), 8'h0);
    wait_until(e + 6);
    vme_bus_request = 4'hF;
    wait_until(e + 9);
    enable = 1'b1;
    wait_drain();

    for (int i = 0; i < 4; i++) arb_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vme_system_arbiter.md
# vme_system_arbiter

VME slot-1 system-controller block: arbitrates the four daisy-chained bus-request levels, drives the four bus-grant chain heads, and runs the global data-transfer bus timer. It sits beside the local VME master interface on the CPU card and is enabled only when the card occupies slot 1. Its grant on the level used by the local card feeds the `vme_bus_grant_in` input of the local arbitration logic through the backplane chain.

## Interface
Parameters:
- `GRANT_TIMEOUT`, default 64: cycles a grant may remain unanswered (no BBSY) before it is withdrawn.
- `BUS_TIMEOUT`, default 1024: cycles a strobed transfer may wait for DTACK/BERR before the arbiter asserts BERR.
- `TIMER_WIDTH`, default 11: counter width; must satisfy 2^TIMER_WIDTH > max(GRANT_TIMEOUT, BUS_TIMEOUT).

Ports (all VME-side signals are active-low):
- `clock` input 1: single system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `enable` input 1: active-high slot-1 strap. When low, every output is held at its inactive value and the FSM is held in IDLE.
- `vme_bus_request` input 4: BR3..BR0, asynchronous.
- `vme_bus_busy` input 1: BBSY, asynchronous.
- `vme_as` input 1: backplane AS, asynchronous.
- `vme_ds` input 2: backplane DS1/DS0, asynchronous.
- `vme_dtack` input 1: backplane DTACK, asynchronous.
- `vme_berr` input 1: backplane BERR, asynchronous.
- `vme_bus_grant_out` output 4: BG3OUT..BG0OUT chain heads.
- `vme_bus_clear` output 1: BCLR.
- `vme_berr_out` output 1: bus-timer BERR; open-drain at the top level.
- `grant_level` output 2: level of the current or most recent grant.
- `timeout_flag` output 1: active-high sticky flag; set on any bus-timer expiry, cleared only by reset.

## Operation
- Input synchronization: every asynchronous input passes through a 2-flop synchronizer. The FSM and timer see only the synchronized values.
- Reset values: `vme_bus_grant_out` = 4'b1111, `vme_bus_clear` = 1, `vme_berr_out` = 1, `grant_level` = 2'b00, `timeout_flag` = 0, FSM in IDLE, counters at 0.
- FSM states:
  - IDLE:
    - If any synchronized request is low and BBSY is high: select a winner, latch `grant_level`, go to GRANT.
    - If BBSY is low: stay in IDLE.
  - GRANT:
    - Drive `vme_bus_grant_out[grant_level]` low and all other bits high.
    - If BBSY goes low: go to BUSY.
    - Else if the grant counter reaches GRANT_TIMEOUT: go to IDLE.
  - BUSY:
    - All grants are high.
    - When BBSY goes high: go to IDLE.
- Arbitration is priority-ordered: BR3 > BR2 > BR1 > BR0.
- A request that is withdrawn during GRANT does not cancel the grant. GRANT ends only on BBSY or timeout.
- Bus clear: in BUSY, if a request strictly higher than `grant_level` is pending, drive `vme_bus_clear` low. BCLR releases in the same cycle BUSY is exited.
- Bus timer (independent of the FSM):
  - Counts while synchronized AS is low, at least one DS is low, DTACK is high, and BERR is high.
  - Clears whenever that condition is false.
  - At count == BUS_TIMEOUT, drive `vme_berr_out` low and set `timeout_flag`.
  - Hold `vme_berr_out` low until both DS are high, then release it and clear the counter.
  - The counter saturates and never wraps.
- Simultaneous events:
  - BBSY low in the same cycle the grant timeout expires: BBSY wins, go to BUSY.
  - `enable` going low in any state: go to IDLE next cycle, all outputs inactive.

## Timing
- Request to grant: a request asserted before rising edge N shows low on `vme_bus_grant_out` after edge N+3 (2 synchronizer edges, 1 to IDLE→GRANT, grant registered with the state).
- BBSY low to grant release: 3 edges.
- BBSY high to next grant: 4 edges minimum (sync 2, BUSY→IDLE 1, IDLE→GRANT 1).
- Grant timeout: the grant is high again exactly GRANT_TIMEOUT edges after it first went low.
- Bus timer: `vme_berr_out` goes low BUS_TIMEOUT+3 edges after the DS strobe (2 sync, BUS_TIMEOUT counts, 1 register).
- All outputs are registered. No combinational input-to-output paths.

## Configuration
- `VME_ROUND_ROBIN_EN`:
  - Defined: round-robin arbitration. Search starts at (last `grant_level` − 1) mod 4, descending and wrapping 0→3. `vme_bus_clear` is never asserted and stays at 1.
  - Undefined: fixed priority BR3 > BR2 > BR1 > BR0, with BCLR behaviour as described under Operation.

## Test plan
- BR1 low from reset, BBSY responds 2 cycles after the grant → BG1OUT low for exactly 5 cycles, `grant_level` = 1, grant at edge N+3.
- BR0 and BR2 asserted together → BG2OUT granted. After BBSY is released with BR0 still asserted, BG0OUT is granted.
- BR3 asserted, BBSY never asserted, GRANT_TIMEOUT = 64 → BG3OUT low for 64 cycles, then high. The grant is re-issued 1 cycle after returning to IDLE.
- In BUSY with `grant_level` = 0, BR2 asserted → `vme_bus_clear` low 3 edges later. With `VME_ROUND_ROBIN_EN` defined, it stays at 1.
- AS and DS0 low, no DTACK, BUS_TIMEOUT = 16 → `vme_berr_out` low at edge 19 and `timeout_flag` = 1. It releases 3 edges after DS goes high. `timeout_flag` stays set.
- Reset pulsed low during GRANT → all grants high immediately (asynchronous). After reset is released, the FSM re-arbitrates from IDLE.
